// File: rtl/anchor_window_addr_gen_pkg.sv
// Shared types and helpers for the anchor-window address generator and its
// tap counter.
package anchor_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        BURST = ST_BURST
    } state_t;

    localparam int KERNEL_SIZE_DEF = 3;
    localparam int TAPS            = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;

    // Signed coordinate width: 32-bit unsigned anchor plus kernel offset minus padding.
    localparam int COORD_W = 34;

    function automatic logic in_image(
        input logic signed [COORD_W-1:0] row,
        input logic signed [COORD_W-1:0] col,
        input logic signed [COORD_W-1:0] height,
        input logic signed [COORD_W-1:0] width
    );
        return (row >= 0) && (row < height) && (col >= 0) && (col < width);
    endfunction

endpackage

// File: rtl/anchor_window_addr_gen_counter.sv
// Nested kr/kc window tap counter. kr_next/kc_next are the values the counter
// takes at the next edge, so callers can register per-tap results in step.
module window_tap_counter #(
    parameter int K  = 3,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] kr_next,
    output logic [CW-1:0] kc_next,
    output logic          first,
    output logic          last
);

    localparam logic [CW-1:0] K_MAX = CW'(K - 1);

    logic [CW-1:0] kr;
    logic [CW-1:0] kc;

    always_comb begin
        kr_next = kr;
        kc_next = kc;
        if (clear) begin
            kr_next = '0;
            kc_next = '0;
        end else if (advance) begin
            if (kc == K_MAX) begin
                kc_next = '0;
                kr_next = (kr == K_MAX) ? '0 : kr + CW'(1);
            end else begin
                kc_next = kc + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        kr <= kr_next;
        kc <= kc_next;
    end

    assign first = (kr == '0) && (kc == '0);
    assign last  = (kr == K_MAX) && (kc == K_MAX);

endmodule

// File: rtl/anchor_window_addr_gen.sv
// Expands each accepted (height, width) anchor into its K x K window of
// feature-map read addresses, row-major, flagging taps that fall in the padding.
module anchor_window_addr_gen
    import anchor_pkg::*;
#(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int PAD         = 1,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  anchor_valid,
    input  logic [31:0]           anchor_height,
    input  logic [31:0]           anchor_width,
    output logic                  anchor_ready,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  pad,
    output logic                  win_first,
    output logic                  win_last
);

    localparam int CW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    state_t                    state;
    logic [31:0]               anc_h;
    logic [31:0]               anc_w;
    logic [CW-1:0]             kr_next;
    logic [CW-1:0]             kc_next;
    logic                      cnt_first;
    logic                      cnt_last;
    logic                      accept;
    logic                      advance;
    logic                      done;
    logic                      clear;
    logic [31:0]               h_src;
    logic [31:0]               w_src;
    logic signed [COORD_W-1:0] row;
    logic signed [COORD_W-1:0] col;
    logic                      tap_pad;
    logic [ADDR_WIDTH-1:0]     tap_addr;

    // Handshakes: a transfer happens on a cycle where valid & ready are both 1;
    // valid never depends on ready, and a presented tap is held until taken.
    assign anchor_ready = (state == IDLE) && enable && !rst;
    assign accept       = anchor_valid && anchor_ready;
    assign advance      = (state == BURST) && addr_valid && addr_ready;
    assign done         = advance && cnt_last;
    assign clear        = rst || !enable || accept || done;

    window_tap_counter #(
        .K  (KERNEL_SIZE),
        .CW (CW)
    ) u_counter (
        .clk     (clk),
        .clear   (clear),
        .advance (advance),
        .kr_next (kr_next),
        .kc_next (kc_next),
        .first   (cnt_first),
        .last    (cnt_last)
    );

    // Tap math runs on the tap about to be registered: the new anchor on
    // acceptance, otherwise the latched anchor at the counter's next position.
    always_comb begin
        h_src    = accept ? anchor_height : anc_h;
        w_src    = accept ? anchor_width  : anc_w;
        row      = signed'({2'b00, h_src}) + signed'(COORD_W'(kr_next)) - COORD_W'(PAD);
        col      = signed'({2'b00, w_src}) + signed'(COORD_W'(kc_next)) - COORD_W'(PAD);
        tap_pad  = !in_image(row, col, COORD_W'(IMG_HEIGHT), COORD_W'(IMG_WIDTH));
        tap_addr = '0;
        if (!tap_pad) begin
            tap_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(row) * ADDR_WIDTH'(IMG_WIDTH)
                     + ADDR_WIDTH'(col);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            anc_h      <= '0;
            anc_w      <= '0;
            addr_valid <= 1'b0;
            rd_addr    <= '0;
            pad        <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            addr_valid <= 1'b0;
            rd_addr    <= '0;
            pad        <= 1'b0;
        end else if (accept) begin
            state      <= BURST;
            anc_h      <= anchor_height;
            anc_w      <= anchor_width;
            addr_valid <= 1'b1;
            rd_addr    <= tap_addr;
            pad        <= tap_pad;
        end else if (done) begin
            state      <= IDLE;
            addr_valid <= 1'b0;
            rd_addr    <= '0;
            pad        <= 1'b0;
        end else if (advance) begin
            rd_addr    <= tap_addr;
            pad        <= tap_pad;
        end
    end

    assign win_first = addr_valid && cnt_first;
    assign win_last  = addr_valid && cnt_last;

endmodule

// File: tb/tb_anchor_window_addr_gen.sv
// Bench for anchor_window_addr_gen: a window-expansion model checked every
// cycle against two instances (BASE_ADDR 0 and 256), plus literal tap lists.
module tb_anchor_window_addr_gen;
    import anchor_pkg::*;

    localparam int IW = 32;
    localparam int IH = 32;
    localparam int K  = 3;
    localparam int P  = 1;
    localparam int BASE_B = 256;

    typedef struct {
        logic [31:0] a0;
        logic [31:0] a1;
        logic        p;
        logic        f;
        logic        l;
    } tap_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        anchor_valid;
    logic [31:0] anchor_height;
    logic [31:0] anchor_width;
    logic        addr_ready;
    logic        anchor_ready, anchor_ready_b;
    logic        addr_valid, addr_valid_b;
    logic [9:0]  rd_addr;
    logic [10:0] rd_addr_b;
    logic        pad, pad_b, win_first, win_first_b, win_last, win_last_b;

    tap_t        exp_q[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_addr_b[$];
    logic        got_pad[$];
    logic        got_last[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        bp_on = 1'b0;

    always #5 clk = ~clk;

    anchor_window_addr_gen dut (
        .clk(clk), .rst(rst), .enable(enable), .anchor_valid(anchor_valid),
        .anchor_height(anchor_height), .anchor_width(anchor_width),
        .anchor_ready(anchor_ready), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .rd_addr(rd_addr), .pad(pad), .win_first(win_first), .win_last(win_last)
    );

    anchor_window_addr_gen #(.BASE_ADDR(BASE_B), .ADDR_WIDTH(11)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .anchor_valid(anchor_valid),
        .anchor_height(anchor_height), .anchor_width(anchor_width),
        .anchor_ready(anchor_ready_b), .addr_valid(addr_valid_b), .addr_ready(addr_ready),
        .rd_addr(rd_addr_b), .pad(pad_b), .win_first(win_first_b), .win_last(win_last_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic tap_t model_tap(input longint h, input longint w, input int kr, input int kc);
        tap_t   t;
        longint r, c;
        r   = h + kr - P;
        c   = w + kc - P;
        t.p = (r < 0) || (r >= IH) || (c < 0) || (c >= IW);
        t.a0 = t.p ? 32'd0 : 32'(r * IW + c);
        t.a1 = t.p ? 32'd0 : 32'(r * IW + c + BASE_B);
        t.f = (kr == 0) && (kc == 0);
        t.l = (kr == K - 1) && (kc == K - 1);
        return t;
    endfunction

    // Compare current outputs with the model, then apply what the next edge does.
    initial begin
        tap_t t;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("addr_valid", 32'(addr_valid), 32'(exp_q.size() != 0));
            check("addr_valid_b", 32'(addr_valid_b), 32'(exp_q.size() != 0));
            check("anchor_ready", 32'(anchor_ready), 32'(exp_q.size() == 0 && enable && !rst));
            check("anchor_ready_b", 32'(anchor_ready_b), 32'(exp_q.size() == 0 && enable && !rst));
            if (exp_q.size() != 0) begin
                t = exp_q[0];
            end else begin
                t = '{a0: 32'd0, a1: 32'd0, p: 1'b0, f: 1'b0, l: 1'b0};
            end
            check("rd_addr", 32'(rd_addr), t.a0);
            check("rd_addr_b", 32'(rd_addr_b), t.a1);
            check("pad", 32'(pad), 32'(t.p));
            check("pad_b", 32'(pad_b), 32'(t.p));
            check("win_first", 32'(win_first), 32'(t.f));
            check("win_last", 32'(win_last), 32'(t.l));
            check("win_last_b", 32'(win_last_b), 32'(t.l));
            if (addr_valid && addr_ready) begin
                got_addr.push_back(32'(rd_addr));
                got_addr_b.push_back(32'(rd_addr_b));
                got_pad.push_back(pad);
                got_last.push_back(win_last);
            end
            if (rst || !enable) begin
                exp_q.delete();
            end else if (exp_q.size() != 0) begin
                if (addr_ready) void'(exp_q.pop_front());
            end else if (anchor_valid) begin
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        exp_q.push_back(model_tap(longint'(anchor_height), longint'(anchor_width), kr, kc));
            end
        end
    end

    // Backpressure pattern 1,0,0,1 repeating while enabled.
    initial begin
        int bp_i;
        logic [3:0] pat;
        bp_i = 0;
        pat  = 4'b1001;
        forever begin
            @(posedge clk);
            #2;
            if (bp_on) begin
                addr_ready = pat[3 - bp_i];
                bp_i = (bp_i + 1) % 4;
            end else begin
                bp_i = 0;
            end
        end
    end

    task automatic send_anchor(input logic [31:0] h, input logic [31:0] w);
        logic taken;
        taken = 1'b0;
        @(posedge clk);
        #2;
        anchor_valid  = 1'b1;
        anchor_height = h;
        anchor_width  = w;
        for (int i = 0; i < 100 && !taken; i++) begin
            @(negedge clk);
            taken = anchor_ready;
            @(posedge clk);
            #2;
        end
        anchor_valid = 1'b0;
        check("handshake_timeout", 32'(taken), 32'd1);
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0);
        end
        check("idle_timeout", 32'(idle), 32'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        got_addr.delete();
        got_addr_b.delete();
        got_pad.delete();
        got_last.delete();
    endtask

    initial begin
        logic [31:0] e1[9];
        logic [31:0] e2a[9];
        logic        e2p[9];
        logic [31:0] e3a[9];
        logic [31:0] e3b[9];
        tap_t        mt;
        int          n_last;

        e1  = '{134, 135, 136, 166, 167, 168, 198, 199, 200};
        e2a = '{0, 0, 0, 0, 0, 1, 0, 32, 33};
        e2p = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
        e3a = '{990, 991, 0, 1022, 1023, 0, 0, 0, 0};
        e3b = '{1246, 1247, 0, 1278, 1279, 0, 0, 0, 0};

        rst = 1'b1; enable = 1'b1; anchor_valid = 1'b0;
        anchor_height = '0; anchor_width = '0; addr_ready = 1'b1;

        // Pin the model against hand-computed taps.
        mt = model_tap(5, 7, 0, 0);
        check("model_5_7_first", mt.a0, 32'd134);
        mt = model_tap(0, 0, 0, 0);
        check("model_0_0_pad", 32'(mt.p), 32'd1);
        mt = model_tap(31, 31, 1, 1);
        check("model_31_31_b", mt.a1, 32'd1279);
        check("taps_const", 32'(TAPS), 32'(K * K));

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Interior anchor, free-flowing.
        clear_logs();
        send_anchor(5, 7);
        wait_idle();
        check("t1_count", 32'(got_addr.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_addr.size(); i++) begin
            check("t1_addr", got_addr[i], e1[i]);
            check("t1_pad", 32'(got_pad[i]), 32'd0);
        end

        // Top-left corner with padding.
        clear_logs();
        send_anchor(0, 0);
        wait_idle();
        check("t2_count", 32'(got_addr.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_addr.size(); i++) begin
            check("t2_addr", got_addr[i], e2a[i]);
            check("t2_pad", 32'(got_pad[i]), 32'(e2p[i]));
        end

        // Bottom-right corner, both base addresses.
        clear_logs();
        send_anchor(31, 31);
        wait_idle();
        check("t3_count", 32'(got_addr.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_addr.size(); i++) begin
            check("t3_addr", got_addr[i], e3a[i]);
            check("t3_addr_b", got_addr_b[i], e3b[i]);
        end

        // Anchor wholly outside the image.
        clear_logs();
        send_anchor(100, 5);
        wait_idle();
        check("t_out_count", 32'(got_addr.size()), 32'd9);
        for (int i = 0; i < got_pad.size(); i++)
            check("t_out_pad", 32'(got_pad[i]), 32'd1);

        // Backpressure.
        clear_logs();
        bp_on = 1'b1;
        send_anchor(5, 7);
        wait_idle();
        bp_on = 1'b0;
        addr_ready = 1'b1;
        check("bp_count", 32'(got_addr.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_addr.size(); i++)
            check("bp_addr", got_addr[i], e1[i]);

        // Abort with enable=0 at tap 4.
        send_anchor(5, 7);
        repeat (4) @(posedge clk);
        #2;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        enable = 1'b1;
        clear_logs();
        send_anchor(1, 1);
        wait_idle();
        check("abort_count", 32'(got_addr.size()), 32'd9);
        if (got_addr.size() != 0) begin
            check("abort_first_addr", got_addr[0], 32'd0);
            check("abort_first_pad", 32'(got_pad[0]), 32'd0);
        end

        // Reset during tap 6, then back-to-back anchors.
        send_anchor(5, 7);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_logs();
        send_anchor(2, 2);
        send_anchor(2, 3);
        wait_idle();
        check("b2b_count", 32'(got_addr.size()), 32'd18);
        n_last = 0;
        for (int i = 0; i < got_last.size(); i++)
            if (got_last[i]) n_last++;
        check("b2b_last_pulses", 32'(n_last), 32'd2);
        if (got_addr.size() == 18) begin
            check("b2b_first", got_addr[0], 32'd33);
            check("b2b_second", got_addr[9], 32'd34);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/anchor_window_addr_gen.md
Name: anchor_window_addr_gen

Overview:
- Consumer end of the 2-D anchor stream in the FPGA CNN datapath. Accepts one (anchor_height, anchor_width) pair per valid/ready handshake.
- Expands each anchor into the KERNEL_SIZE x KERNEL_SIZE feature-map read addresses of its convolution window, row-major, with zero-padding flags.
- Feeds the feature-map buffer read port and the MAC array input stage.

Parameters:
- IMG_WIDTH, 32, feature-map columns.
- IMG_HEIGHT, 32, feature-map rows.
- KERNEL_SIZE, 3, window side K (1..7).
- PAD, 1, zero-padding border width (0..K-1).
- BASE_ADDR, 0, buffer base address added to every in-range address.
- ADDR_WIDTH, 10, read address width; must hold BASE_ADDR+IMG_WIDTH*IMG_HEIGHT-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  0 = abort and hold idle; 1 = run.
- anchor_valid  in  1  anchor pair present.
- anchor_height  in  32  anchor row (unsigned).
- anchor_width  in  32  anchor column (unsigned).
- anchor_ready  out  1  block accepts an anchor this cycle.
- addr_valid  out  1  rd_addr/pad/first/last valid.
- addr_ready  in  1  downstream accepts the current address.
- rd_addr  out  ADDR_WIDTH  feature-map read address; 0 when pad=1.
- pad  out  1  window tap lies outside the image; consumer substitutes zero.
- win_first  out  1  first tap of window (kr=0,kc=0).
- win_last  out  1  last tap of window (kr=K-1,kc=K-1).

Behaviour:
- Reset (rst=1 at edge): state=IDLE, kr=kc=0, latched anchor=0, addr_valid=0, rd_addr=0, pad=0, win_first=0, win_last=0. anchor_ready is combinational and =0 during reset.
- anchor_ready = (state==IDLE) & enable & !rst.
- FSM IDLE:
  - When anchor_valid & anchor_ready: latch h,w; kr=kc=0; go to BURST.
  - Next cycle addr_valid=1 with tap (0,0). Acceptance-to-first-address latency is 1 cycle.
- FSM BURST:
  - All outputs are registered and held stable while addr_valid & !addr_ready (no change under backpressure).
  - On addr_ready: advance kc. When kc wraps from K-1 to 0, increment kr.
  - The tap with win_last=1 accepted -> addr_valid=0 next cycle, state=IDLE.
  - Minimum period per anchor: K*K+1 cycles.
- Tap math, signed 34-bit:
  - row = h + kr - PAD; col = w + kc - PAD.
  - pad = (row<0) | (row>=IMG_HEIGHT) | (col<0) | (col>=IMG_WIDTH).
  - rd_addr = pad ? 0 : BASE_ADDR + row*IMG_WIDTH + col, truncated to ADDR_WIDTH.
- Anchors wholly outside the image are legal: all K*K taps are emitted with pad=1.
- win_first=1 only on tap (0,0); win_last=1 only on tap (K-1,K-1). Both are 1 when K=1.
- enable=0 in any state: next cycle state=IDLE, addr_valid=0, counters cleared. Any partial window is discarded with no win_last.
- rst mid-burst: identical to enable=0, plus latched anchor cleared.
- anchor_valid while BURST: ignored (ready=0). The upstream generator must hold the pair stable.

Decomposition:
- Package anchor_pkg:
  - state enum {IDLE, BURST}.
  - localparam TAPS=KERNEL_SIZE*KERNEL_SIZE.
  - signed coordinate width constant (34).
  - function in_image(row,col).
- Sub-module window_tap_counter:
  - Nested kr/kc counter with clear, advance, first and last outputs.
  - Reused later by the output write-back side.

Test Plan:
- Defaults, anchor (5,7), addr_ready=1: 9 taps with pad=0, rd_addr = 134,135,136,166,167,168,198,199,200. win_first on 134, win_last on 200. addr_valid rises 1 cycle after handshake; anchor_ready returns to 1 the cycle after 200.
- Anchor (0,0): pad sequence 1,1,1,1,0,0,1,0,0. Non-pad rd_addr = 0,1,32,33. Padded taps show rd_addr=0.
- Anchor (31,31): rd_addr 990,991,pad,1022,1023,pad,pad,pad,pad. BASE_ADDR=256 variant shifts non-pad addresses by +256 (990 -> 1246).
- Backpressure: anchor (5,7), addr_ready toggled 1,0,0,1,... Each tap is held unchanged while ready=0. Sequence is identical to the first test; no tap dropped or duplicated.
- Abort: enable=0 during tap 4 of anchor (5,7) -> addr_valid=0 next cycle, anchor_ready=0 while enable=0. After enable=1, new anchor (1,1) starts at tap 0 with rd_addr = pad=0, 0.
- Reset mid-burst: rst=1 for 1 cycle during tap 6 -> all outputs zero next cycle. Back-to-back anchors (2,2),(2,3) after release produce 18 taps with exactly 2 win_last pulses.
